// File: rtl/pointer_ctl.sv
// IP/DP pointer-pair sequencer: one command at a time over valid/ready,
// every control line driven straight from a flop.
module pointer_ctl #(
  parameter int LEN_W  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             addr_dp,
  output logic             n_oe_dl,
  output logic             n_oe_dh,
  output logic             cnt,
  output logic             n_we_l,
  output logic             n_we_h,
  output logic             selector,
  output logic             busy,
  output logic             done
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, NOPS, FETCH, WL, WH, RL, RH, DMEM, SWAP, SETT
  } state_t;

  state_t           state, nxt;
  logic [LEN_W-1:0] rep, rep_n;
  logic [SW-1:0]    sc, sc_n;
  logic             jmp, jmp_n;
  logic             done_n;

  // done doubles as "final cycle", so accept happens in IDLE or on done
  always_comb begin
    nxt   = state;
    rep_n = rep;
    sc_n  = sc;
    jmp_n = jmp;
    if (state == IDLE || done) begin
      nxt = IDLE;
      if (cmd_valid) begin
        rep_n = cmd_len;
        jmp_n = (cmd_op == 3'd6);
        unique case (cmd_op)
          3'd1:       nxt = FETCH;
          3'd2, 3'd6: nxt = WL;
          3'd3:       nxt = RL;
          3'd4:       nxt = DMEM;
          3'd5:       nxt = SWAP;
          default:    nxt = NOPS;
        endcase
      end
    end else begin
      unique case (state)
        FETCH, DMEM: rep_n = rep - 1'b1;
        WL:          nxt = WH;
        WH:          nxt = SWAP;
        RL:          nxt = RH;
        SWAP: begin
          nxt  = SETT;
          sc_n = SW'(SETTLE - 1);
        end
        SETT:        sc_n = sc - 1'b1;
        default:     nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    done_n = 1'b0;
    unique case (nxt)
      NOPS, RH:    done_n = 1'b1;
      FETCH, DMEM: done_n = (rep_n == '0);
      WH:          done_n = !jmp_n;
      SWAP:        done_n = (SETTLE == 0);
      SETT:        done_n = (sc_n == '0);
      default:     done_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      rep       <= '0;
      sc        <= '0;
      jmp       <= 1'b0;
      selector  <= 1'b0;
      addr_dp   <= 1'b0;
      cnt       <= 1'b0;
      n_oe_dl   <= 1'b1;
      n_oe_dh   <= 1'b1;
      n_we_l    <= 1'b1;
      n_we_h    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= nxt;
      rep       <= rep_n;
      sc        <= sc_n;
      jmp       <= jmp_n;
      selector  <= selector ^ (state == SWAP);
      addr_dp   <= (nxt == DMEM);
      cnt       <= (nxt == FETCH);
      n_oe_dl   <= (nxt != RL);
      n_oe_dh   <= (nxt != RH);
      n_we_l    <= (nxt != WL);
      n_we_h    <= (nxt != WH);
      busy      <= (nxt != IDLE);
      done      <= done_n;
      cmd_ready <= (nxt == IDLE) || done_n;
    end
  end

endmodule

// File: tb/tb_pointer_ctl.sv
// Directed, table-driven bench for pointer_ctl with hand-written
// sequences for reset and back-to-back corner cases.
module tb_pointer_ctl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_len = 2'd0;
  logic       addr_dp, n_oe_dl, n_oe_dh, cnt;
  logic       n_we_l, n_we_h, selector, busy, done;

  pointer_ctl #(.LEN_W(2), .SETTLE(1)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len),
    .addr_dp(addr_dp), .n_oe_dl(n_oe_dl), .n_oe_dh(n_oe_dh),
    .cnt(cnt), .n_we_l(n_we_l), .n_we_h(n_we_h),
    .selector(selector), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {addr_dp, cnt, n_oe_dl, n_oe_dh, n_we_l, n_we_h}
  localparam logic [5:0] CI  = 6'b001111;
  localparam logic [5:0] CF  = 6'b011111;
  localparam logic [5:0] CD  = 6'b101111;
  localparam logic [5:0] CRL = 6'b000111;
  localparam logic [5:0] CRH = 6'b001011;
  localparam logic [5:0] CWL = 6'b001101;
  localparam logic [5:0] CWH = 6'b001110;

  typedef struct {
    logic [2:0] op;
    logic [1:0] len;
    int         n;
    logic [5:0] w0, w1, w2, w3;
    logic       flip;
    int         ipadv;
  } vec_t;

  int total = 0;
  int passed = 0;

  function automatic logic [5:0] ctl();
    return {addr_dp, cnt, n_oe_dl, n_oe_dh, n_we_l, n_we_h};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic prev_sel = 1'b0;
  logic prev_sw = 1'b0;
  always @(negedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_sel = 1'b0;
      prev_sw  = 1'b0;
    end else begin
      chk("inv_onehot_low",
          32'($countones({~n_oe_dl, ~n_oe_dh, ~n_we_l, ~n_we_h}) <= 1), 1);
      chk("inv_cnt_addr", 32'(cnt && addr_dp), 0);
      if (selector != prev_sel) chk("inv_sel_after_swap", 32'(prev_sw), 1);
      prev_sel = selector;
      prev_sw  = busy && !done && (ctl() == CI);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic apply(vec_t v, int idx);
    logic sel0;
    logic [5:0] w;
    int ipc = 0;
    wait_ready();
    sel0 = selector;
    cmd_valid = 1'b1;
    cmd_op = v.op;
    cmd_len = v.len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'd1;
    cmd_len = ~v.len;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : (i == 2) ? v.w2 : v.w3;
      chk($sformatf("v%0d_c%0d_ctl", idx, i), 32'(ctl()), 32'(w));
      chk($sformatf("v%0d_c%0d_busy", idx, i), 32'(busy), 1);
      chk($sformatf("v%0d_c%0d_done", idx, i), 32'(done),
          32'(i == v.n - 1));
      chk($sformatf("v%0d_c%0d_ready", idx, i), 32'(cmd_ready),
          32'(i == v.n - 1));
      chk($sformatf("v%0d_c%0d_sel", idx, i), 32'(selector),
          32'(sel0 ^ (v.flip && i == v.n - 1)));
      if (cnt) ipc++;
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 0);
    chk($sformatf("v%0d_idle_ctl", idx), 32'(ctl()), 32'(CI));
    chk($sformatf("v%0d_ipadv", idx), 32'(ipc), 32'(v.ipadv));
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ctl"}, 32'(ctl()), 32'(CI));
    chk({tag, "_sel"}, 32'(selector), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{3'd0, 2'd0, 1, CI,  CI,  CI, CI, 1'b0, 0};
    vt[1]  = '{3'd7, 2'd3, 1, CI,  CI,  CI, CI, 1'b0, 0};
    vt[2]  = '{3'd1, 2'd2, 3, CF,  CF,  CF, CF, 1'b0, 3};
    vt[3]  = '{3'd1, 2'd0, 1, CF,  CF,  CF, CF, 1'b0, 1};
    vt[4]  = '{3'd1, 2'd3, 4, CF,  CF,  CF, CF, 1'b0, 4};
    vt[5]  = '{3'd4, 2'd3, 4, CD,  CD,  CD, CD, 1'b0, 0};
    vt[6]  = '{3'd4, 2'd0, 1, CD,  CD,  CD, CD, 1'b0, 0};
    vt[7]  = '{3'd2, 2'd1, 2, CWL, CWH, CI, CI, 1'b0, 0};
    vt[8]  = '{3'd3, 2'd2, 2, CRL, CRH, CI, CI, 1'b0, 0};
    vt[9]  = '{3'd5, 2'd0, 2, CI,  CI,  CI, CI, 1'b1, 0};
    vt[10] = '{3'd6, 2'd0, 4, CWL, CWH, CI, CI, 1'b1, 0};
    vt[11] = '{3'd6, 2'd3, 4, CWL, CWH, CI, CI, 1'b1, 0};

    repeat (2) @(negedge clk);
    chk_reset("rst_hold");
    n_rst = 1'b1;
    @(negedge clk);

    // Async reset mid-FETCH with selector already toggled
    apply(vt[9], 100);
    chk("pre_rst_sel", 32'(selector), 1);
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_len = 2'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("fetch_cnt_pre_rst", 32'(cnt), 1);
    #2 n_rst = 1'b0;
    #1 chk_reset("rst_async");
    #1 n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) apply(vt[i], i);
    chk("jmp_pair_sel", 32'(selector), 1);

    // Back-to-back FETCH len0 then SDP, valid held across
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_len = 2'd0;
    @(posedge clk);
    #1;
    cmd_op = 3'd3;
    cmd_len = 2'd2;
    @(negedge clk);
    chk("b2b_c1_ctl", 32'(ctl()), 32'(CF));
    chk("b2b_c1_done", 32'(done), 1);
    chk("b2b_c1_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c2_ctl", 32'(ctl()), 32'(CRL));
    chk("b2b_c2_done", 32'(done), 0);
    @(negedge clk);
    chk("b2b_c3_ctl", 32'(ctl()), 32'(CRH));
    chk("b2b_c3_done", 32'(done), 1);
    @(negedge clk);
    chk("b2b_c4_busy", 32'(busy), 0);

    // Reset during WH of LDP, then a clean LDP
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("ldp_rst_wl", 32'(n_we_l), 0);
    @(negedge clk);
    chk("ldp_rst_wh", 32'(n_we_h), 0);
    #2 n_rst = 1'b0;
    #1;
    chk("ldp_rst_weh", 32'(n_we_h), 1);
    chk("ldp_rst_busy", 32'(busy), 0);
    #1 n_rst = 1'b1;
    @(negedge clk);
    apply(vt[7], 107);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
